// File: rtl/int_div_iterative_pkg.sv
// Shared definitions for the iterative integer divider: FSM encodings,
// operation-kind encoding and the position of each half in the 2W-bit result.
package int_div_iterative_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic FN_UNSIGNED = 1'b0;
  localparam logic FN_SIGNED   = 1'b1;

  // Result halves are W bits wide; the field index scales by W at the use site.
  localparam int QUOT_FIELD = 0;
  localparam int REM_FIELD  = 1;

endpackage

// File: rtl/int_div_iterative_dpath.sv
// Divider datapath: restoring shift/subtract on magnitudes, iteration counter,
// and output-side sign / divide-by-zero correction.
module int_div_iterative_dpath
  import int_div_iterative_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           calc,
  input  logic           fn,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           counter_is_zero,
  output logic [2*W-1:0] result
);

  localparam int CNT_W = $clog2(W);

  function automatic logic [W-1:0] negate_if(input logic [W-1:0] v, input logic en);
    return en ? (W'(0) - v) : v;
  endfunction

  logic [2*W-1:0] r_q, r_d;
  logic [W-1:0]   b_mag_q, b_mag_d;
  logic [W-1:0]   a_q, a_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;
  logic           dbz_q, dbz_d;
  logic           result_vld_q, result_vld_d;

  logic           is_signed;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     rem_ext;
  logic           no_borrow;
  logic [W-1:0]   diff;
  logic [W-1:0]   quo, rem;

  assign is_signed = (fn == FN_SIGNED);
  assign a_mag = (is_signed && a[W-1]) ? (W'(0) - a) : a;
  assign b_mag = (is_signed && b[W-1]) ? (W'(0) - b) : b;

  // The bit shifted out of the top is kept so divisors >= 2^(W-1) still work.
  assign rem_ext   = r_q[2*W-1:W-1];
  assign no_borrow = (rem_ext >= {1'b0, b_mag_q});
  assign diff      = rem_ext[W-1:0] - b_mag_q;

  assign counter_is_zero = (cnt_q == '0);

  always_comb begin
    r_d          = r_q;
    b_mag_d      = b_mag_q;
    a_d          = a_q;
    cnt_d        = cnt_q;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    dbz_d        = dbz_q;
    result_vld_d = result_vld_q;
    if (load) begin
      r_d       = {{W{1'b0}}, a_mag};
      b_mag_d   = b_mag;
      a_d       = a;
      cnt_d     = CNT_W'(W - 1);
      neg_quo_d = is_signed && (a[W-1] ^ b[W-1]);
      neg_rem_d = is_signed && a[W-1];
      dbz_d     = (b == '0);
    end else if (calc) begin
      r_d   = {(no_borrow ? diff : rem_ext[W-1:0]), r_q[W-2:0], no_borrow};
      cnt_d = cnt_q - CNT_W'(1);
      if (counter_is_zero) result_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q          <= '0;
      b_mag_q      <= '0;
      a_q          <= '0;
      cnt_q        <= '0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      dbz_q        <= 1'b0;
      result_vld_q <= 1'b0;
    end else begin
      r_q          <= r_d;
      b_mag_q      <= b_mag_d;
      a_q          <= a_d;
      cnt_q        <= cnt_d;
      neg_quo_q    <= neg_quo_d;
      neg_rem_q    <= neg_rem_d;
      dbz_q        <= dbz_d;
      result_vld_q <= result_vld_d;
    end
  end

  // Divide-by-zero overrides the magnitude path; remainder is the original dividend.
  assign quo = dbz_q ? {W{1'b1}} : negate_if(r_q[W-1:0], neg_quo_q);
  assign rem = dbz_q ? a_q : negate_if(r_q[2*W-1:W], neg_rem_q);

  always_comb begin
    result = '0;
    if (result_vld_q) begin
      result[QUOT_FIELD*W +: W] = quo;
      result[REM_FIELD*W +: W]  = rem;
    end
  end

endmodule

// File: rtl/int_div_iterative.sv
// Iterative restoring divider top: val/rdy request/response control FSM
// around the shift/subtract datapath. Result is {remainder, quotient}.
module int_div_iterative
  import int_div_iterative_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           divreq_msg_fn,
  input  logic [W-1:0]   divreq_msg_a,
  input  logic [W-1:0]   divreq_msg_b,
  input  logic           divreq_val,
  output logic           divreq_rdy,
  output logic [2*W-1:0] divresp_msg_result,
  output logic           divresp_val,
  input  logic           divresp_rdy
);

  state_e state_q, state_d;
  logic   divreq_rdy_q, divreq_rdy_d;
  logic   divresp_val_q, divresp_val_d;
  logic   accept;
  logic   counter_is_zero;

  assign accept      = divreq_val && divreq_rdy_q;
  assign divreq_rdy  = divreq_rdy_q;
  assign divresp_val = divresp_val_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (counter_is_zero) state_d = DONE;
      DONE:    if (divresp_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    divreq_rdy_d  = (state_d == IDLE);
    divresp_val_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      divreq_rdy_q  <= 1'b1;
      divresp_val_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      divreq_rdy_q  <= divreq_rdy_d;
      divresp_val_q <= divresp_val_d;
    end
  end

  int_div_iterative_dpath #(.W(W)) u_dpath (
    .clk             (clk),
    .reset           (reset),
    .load            (accept),
    .calc            (state_q == CALC),
    .fn              (divreq_msg_fn),
    .a               (divreq_msg_a),
    .b               (divreq_msg_b),
    .counter_is_zero (counter_is_zero),
    .result          (divresp_msg_result)
  );

endmodule

// File: tb/tb_int_div_iterative.sv
// Self-checking bench for int_div_iterative: directed cases plus randomized
// operations checked against an arithmetic reference model.
module tb_int_div_iterative;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          divreq_msg_fn;
  logic [W-1:0]  divreq_msg_a;
  logic [W-1:0]  divreq_msg_b;
  logic          divreq_val;
  logic          divreq_rdy;
  logic [2*W-1:0] divresp_msg_result;
  logic          divresp_val;
  logic          divresp_rdy;

  int checks = 0;
  int errors = 0;

  int_div_iterative #(.W(W)) dut (
    .clk                (clk),
    .reset              (reset),
    .divreq_msg_fn      (divreq_msg_fn),
    .divreq_msg_a       (divreq_msg_a),
    .divreq_msg_b       (divreq_msg_b),
    .divreq_val         (divreq_val),
    .divreq_rdy         (divreq_rdy),
    .divresp_msg_result (divresp_msg_result),
    .divresp_val        (divresp_val),
    .divresp_rdy        (divresp_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V DIV/DIVU/REM/REMU semantics from plain arithmetic.
  function automatic logic [63:0] model(input logic f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!f) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {r, q};
  endfunction

  task automatic run_op(input string tag, input logic f, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int hold);
    int k;
    @(negedge clk);
    divreq_msg_fn = f;
    divreq_msg_a  = a;
    divreq_msg_b  = b;
    divreq_val    = 1'b1;
    divresp_rdy   = (hold == 0);
    k = 0;
    while (!divreq_rdy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check($sformatf("%s req_rdy_timeout", tag), 64'(divreq_rdy), 64'd1);
    // Accept edge follows; scramble request inputs afterwards to prove they are ignored.
    @(negedge clk);
    divreq_val    = 1'b0;
    divreq_msg_fn = ~f;
    divreq_msg_a  = $urandom;
    divreq_msg_b  = $urandom;
    k = 1;
    while (!divresp_val && k < 100) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("%s latency", tag), 64'(k), 64'd33);
    check($sformatf("%s result", tag), divresp_msg_result, exp);
    for (int i = 0; i < hold; i++) begin
      divreq_val   = 1'b1;
      divreq_msg_a = $urandom;
      divreq_msg_b = $urandom;
      @(negedge clk);
      divreq_val = 1'b0;
      check($sformatf("%s held_result", tag), divresp_msg_result, exp);
      check($sformatf("%s held_val_rdy", tag), {62'd0, divresp_val, divreq_rdy}, 64'b10);
    end
    divresp_rdy = 1'b1;
    check($sformatf("%s rdy_low_at_handshake", tag), 64'(divreq_rdy), 64'd0);
    @(negedge clk);
    check($sformatf("%s after_handshake", tag), {62'd0, divresp_val, divreq_rdy}, 64'b01);
  endtask

  initial begin
    logic        f;
    logic [31:0] a, b;
    int          sel, k;
    logic        seen_val;

    reset         = 1'b1;
    divreq_msg_fn = 1'b0;
    divreq_msg_a  = '0;
    divreq_msg_b  = '0;
    divreq_val    = 1'b0;
    divresp_rdy   = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_rdy", 64'(divreq_rdy), 64'd1);
    check("reset_val", 64'(divresp_val), 64'd0);
    check("reset_result", divresp_msg_result, 64'd0);

    run_op("udiv_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 0);
    run_op("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 0);
    run_op("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 0);
    run_op("sdiv_5_0", 1'b1, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 0);
    run_op("udiv_min_0", 1'b0, 32'h8000_0000, 32'd0, 64'h80000000_FFFFFFFF, 0);
    run_op("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 0);
    run_op("udiv_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h80000000_00000000, 0);
    run_op("udiv_bp", 1'b0, 32'hFFFF_FFFF, 32'h10, 64'h0000000F_0FFFFFFF, 10);

    // Reset in the middle of CALC aborts the operation.
    @(negedge clk);
    divresp_rdy   = 1'b1;
    divreq_msg_fn = 1'b0;
    divreq_msg_a  = 32'd1000;
    divreq_msg_b  = 32'd3;
    divreq_val    = 1'b1;
    k = 0;
    while (!divreq_rdy && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    divreq_val = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_rdy", 64'(divreq_rdy), 64'd1);
    check("abort_result", divresp_msg_result, 64'd0);
    seen_val = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen_val = seen_val | divresp_val;
    end
    check("abort_no_val", 64'(seen_val), 64'd0);
    run_op("udiv_7_7", 1'b0, 32'd7, 32'd7, 64'h00000000_00000001, 0);

    for (int n = 0; n < 40; n++) begin
      f   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 7);
      a   = (sel == 7) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        3:       b = 32'h8000_0000 | $urandom;
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d", n), f, a, b, model(f, a, b), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_div_iterative.md
Name: int_div_iterative

Overview:
- Iterative restoring integer divider with val/rdy request and response interfaces. It is the inverse-operation companion to the team's iterative multiplier.
- Sits beside the multiplier in the imuldiv unit and serves RISC-V DIV/DIVU/REM/REMU.
- Each request produces one 2W-bit response: {remainder, quotient}.
- One quotient bit per cycle; fixed latency.

Parameters:
- W, 32, operand width. Result is 2W. Iteration counter width is clog2(W).

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- divreq_msg_fn  input  1  0 = unsigned (DIVU/REMU), 1 = signed (DIV/REM)
- divreq_msg_a  input  W  dividend
- divreq_msg_b  input  W  divisor
- divreq_val  input  1  request valid
- divreq_rdy  output  1  request ready
- divresp_msg_result  output  2W  {remainder[2W-1:W], quotient[W-1:0]}
- divresp_val  output  1  response valid
- divresp_rdy  input  1  response ready

Behaviour:
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC on divreq_val & divreq_rdy.
  - CALC -> DONE when the counter reaches 0 at the end of the final iteration.
  - DONE -> IDLE on divresp_rdy.
- Outputs per state:
  - divreq_rdy = 1 only in IDLE.
  - divresp_val = 1 only in DONE.
  - The next request cannot be accepted in the same cycle the response is consumed; divreq_rdy rises the cycle after.
- Reset:
  - State goes to IDLE; divreq_rdy = 1 and divresp_val = 0 from the first cycle after reset.
  - Datapath registers are cleared to 0; divresp_msg_result reads 0 until the first completion.
- Handshake capture:
  - On the accept cycle t, register |a|, |b|, the sign flags and fn, and load the counter with W-1.
  - Request inputs are ignored at all other times; changes during CALC have no effect.
- Iteration, one per CALC cycle (W cycles total):
  - Remainder/quotient register R, 2W bits, loaded as {0, |a|}.
  - Each cycle: shift R left by 1, then compute a (W+1)-bit diff = R[2W-1:W] - |b|.
  - If there is no borrow: R[2W-1:W] = diff and R[0] = 1.
  - Counter decrements each cycle.
- Latency: divresp_val = 1 in cycle t+W+1 (t+33 for W=32). Held until divresp_rdy.
- Sign correction, applied combinationally at the output (signed fn only):
  - Quotient is negated when sign(a) XOR sign(b).
  - Remainder is negated when sign(a); remainder sign follows the dividend.
  - Unsigned fn: no correction.
- Divide by zero (b == 0), both fn:
  - Quotient = all ones.
  - Remainder = original a (not |a|).
  - Produced by a flag captured at accept that overrides the output; latency unchanged.
- Signed overflow (a = -2^(W-1), b = -1):
  - Quotient = 0x80000000, remainder = 0.
  - This falls out of the unsigned magnitude path; no special case needed, but it must be verified.
- Backpressure: divresp_msg_result and divresp_val stay stable while in DONE with divresp_rdy = 0.
- Reset mid-operation (CALC or DONE): abort; the pending response is never delivered; return to IDLE.
- Counter wrap: the counter is never used past 0. The exit condition is counter == 0 in CALC.

Decomposition:
- Shared package holds:
  - State encodings: IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2.
  - fn encoding: FN_UNSIGNED = 1'b0, FN_SIGNED = 1'b1.
  - Result field slice positions.
- One sub-module: int_div_iterative_dpath.
  - Contents: operand, R and counter registers, subtractor, sign and div-by-zero correction.
  - Control signals come from the FSM in the top. The dpath returns counter_is_zero.

Test Plan:
- Unsigned 100 / 7, divresp_rdy held 1 -> result 0x00000002_0000000E; divresp_val first high exactly 33 cycles after the accept cycle; divreq_rdy high the cycle after the response handshake.
- Signed -7 / 2 (0xFFFFFFF9, 0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero: signed 5 / 0 -> {0x00000005, 0xFFFFFFFF}; unsigned 0x80000000 / 0 -> {0x80000000, 0xFFFFFFFF}.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}; unsigned same operands -> {0x80000000, 0x00000000}.
- Backpressure: unsigned 0xFFFFFFFF / 0x10 with divresp_rdy low for 10 cycles after val rises -> result {0x0000000F, 0x0FFFFFFF} held stable; divreq_rdy stays 0; operand changes on the request inputs are ignored.
- Reset asserted 10 cycles into CALC -> divresp_val never rises; divreq_rdy = 1 the cycle after reset drops; a following unsigned 7 / 7 -> {0x00000000, 0x00000001}.
